// File: rtl/move_controller_pkg.sv
// Shared chess types for the move controller.
//   piece_t    : 4-bit square code, [3]=black, [2:0] piece type (0 = empty)
//   board_t    : packed [row][col] board of piece_t, row 0 is the white back rank
//   mc_state_t : turn sequencer states
//   INIT_BOARD : standard start position
package move_controller_pkg;

    typedef logic [3:0] piece_t;

    localparam piece_t EMPTY  = 4'd0;
    localparam piece_t PAWN   = 4'd1;
    localparam piece_t ROOK   = 4'd2;
    localparam piece_t KNIGHT = 4'd3;
    localparam piece_t BISHOP = 4'd4;
    localparam piece_t QUEEN  = 4'd5;
    localparam piece_t KING   = 4'd6;
    localparam piece_t BLACK  = 4'd8;

    localparam int COLOR_BIT = 3;

    typedef piece_t [7:0][7:0] board_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUERY,
        ST_WAIT_DST,
        ST_COMMIT,
        ST_OVER
    } mc_state_t;

    function automatic piece_t back_rank(input int col);
        case (col)
            0, 7:    return ROOK;
            1, 6:    return KNIGHT;
            2, 5:    return BISHOP;
            3:       return QUEEN;
            default: return KING;
        endcase
    endfunction

    function automatic board_t init_board();
        board_t b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = back_rank(c);
            b[1][c] = PAWN;
            b[6][c] = PAWN | BLACK;
            b[7][c] = back_rank(c) | BLACK;
        end
        return b;
    endfunction

    localparam board_t INIT_BOARD = init_board();

    function automatic piece_t piece_at(input board_t b, input logic [5:0] sq);
        return b[sq[5:3]][sq[2:0]];
    endfunction

endpackage

// File: rtl/move_controller_if.sv
// Game bus between the move controller, the move generator and the UI.
//   slave  : move controller side (consumes clicks / move mask, drives board + status)
//   master : environment side (UI, move generator, renderer)
// Signals:
//   new_game, click_valid, click_pos[5:0] ([5:3] row, [2:0] col), possible_moves[63:0]
//   query_figure[4:0], query_pos[5:0], board, highlight[63:0], selected, sel_pos[5:0],
//   turn, move_done, illegal, game_over
interface move_controller_if;
    import move_controller_pkg::*;

    logic        new_game;
    logic        click_valid;
    logic [5:0]  click_pos;
    logic [63:0] possible_moves;
    logic [4:0]  query_figure;
    logic [5:0]  query_pos;
    board_t      board;
    logic [63:0] highlight;
    logic        selected;
    logic [5:0]  sel_pos;
    logic        turn;
    logic        move_done;
    logic        illegal;
    logic        game_over;

    modport slave (
        input  new_game, click_valid, click_pos, possible_moves,
        output query_figure, query_pos, board, highlight, selected, sel_pos,
               turn, move_done, illegal, game_over
    );

    modport master (
        output new_game, click_valid, click_pos, possible_moves,
        input  query_figure, query_pos, board, highlight, selected, sel_pos,
               turn, move_done, illegal, game_over
    );

endinterface

// File: rtl/move_controller_board_reg.sv
// Live board storage.
//   clk, rst     : clock, synchronous active-high reset (loads start position)
//   i_load_init  : synchronous reload of the start position (wins over writes)
//   i_wr_en      : commit a move: clear i_src, write i_dst_val to i_dst
//   i_turn       : side whose pieces make up o_own_mask
//   o_board      : registered board
//   o_own_mask   : bit sq set when sq holds a piece of colour i_turn
module move_controller_board_reg
    import move_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load_init,
    input  logic        i_wr_en,
    input  logic [5:0]  i_src,
    input  logic [5:0]  i_dst,
    input  piece_t      i_dst_val,
    input  logic        i_turn,
    output board_t      o_board,
    output logic [63:0] o_own_mask
);

    board_t       r_board;
    logic [255:0] w_flat;

    always_ff @(posedge clk) begin
        if (rst || i_load_init) begin
            r_board <= INIT_BOARD;
        end else if (i_wr_en) begin
            r_board[i_src[5:3]][i_src[2:0]] <= EMPTY;
            r_board[i_dst[5:3]][i_dst[2:0]] <= i_dst_val;
        end
    end

    assign o_board = r_board;
    assign w_flat  = r_board;

    for (genvar gi = 0; gi < 64; gi++) begin : g_own
        assign o_own_mask[gi] = (w_flat[gi*4 +: 3] != 3'd0) &&
                                (w_flat[gi*4 + COLOR_BIT] == i_turn);
    end

endmodule

// File: rtl/move_controller.sv
// Turn/move sequencer: select -> query move generator -> destination -> commit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : move_controller_if.slave (clicks, generator query/mask, board, UI status)
// MOVE_LAT is the number of cycles the generator needs after query_figure/query_pos
// settle before possible_moves is sampled (1..3).
module move_controller
    import move_controller_pkg::*;
#(
    parameter int MOVE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    move_controller_if.slave bus
);

    mc_state_t   r_state, w_state_nx;
    logic [5:0]  r_sel_pos, w_sel_pos_nx;
    piece_t      r_sel_fig, w_sel_fig_nx;
    logic [5:0]  r_dst, w_dst_nx;
    logic [1:0]  r_cnt, w_cnt_nx;
    logic [63:0] r_highlight, w_highlight_nx;
    logic        r_selected, w_selected_nx;
    logic        r_turn, w_turn_nx;
    logic        r_move_done, w_move_done_nx;
    logic        r_illegal, w_illegal_nx;
    logic        r_game_over, w_game_over_nx;
    logic [4:0]  r_qfig, w_qfig_nx;
    logic [5:0]  r_qpos, w_qpos_nx;

    board_t      w_board;
    logic [63:0] w_own_mask;
    logic [63:0] w_mask;
    piece_t      w_click_piece;
    piece_t      w_captured;
    piece_t      w_dst_val;
    logic        w_click_own;
    logic        w_promote;
    logic        w_wr_en;

    move_controller_board_reg u_board (
        .clk         (clk),
        .rst         (rst),
        .i_load_init (bus.new_game),
        .i_wr_en     (w_wr_en),
        .i_src       (r_sel_pos),
        .i_dst       (r_dst),
        .i_dst_val   (w_dst_val),
        .i_turn      (r_turn),
        .o_board     (w_board),
        .o_own_mask  (w_own_mask)
    );

    assign w_click_piece = piece_at(w_board, bus.click_pos);
    assign w_click_own   = w_own_mask[bus.click_pos];
    assign w_captured    = piece_at(w_board, r_dst);
    assign w_mask        = bus.possible_moves & ~w_own_mask;

    // Pawn reaching the far rank of its colour turns into a queen of that colour.
    assign w_promote = (r_sel_fig[2:0] == PAWN[2:0]) &&
                       (r_sel_fig[COLOR_BIT] ? (r_dst[5:3] == 3'd0) : (r_dst[5:3] == 3'd7));
    assign w_dst_val = w_promote ? {r_sel_fig[COLOR_BIT], QUEEN[2:0]} : r_sel_fig;

    always_comb begin
        w_state_nx     = r_state;
        w_sel_pos_nx   = r_sel_pos;
        w_sel_fig_nx   = r_sel_fig;
        w_dst_nx       = r_dst;
        w_cnt_nx       = r_cnt;
        w_highlight_nx = r_highlight;
        w_selected_nx  = r_selected;
        w_turn_nx      = r_turn;
        w_move_done_nx = 1'b0;
        w_illegal_nx   = 1'b0;
        w_game_over_nx = r_game_over;
        w_qfig_nx      = r_qfig;
        w_qpos_nx      = r_qpos;
        w_wr_en        = 1'b0;

        if (bus.new_game) begin
            w_state_nx     = ST_IDLE;
            w_sel_pos_nx   = '0;
            w_sel_fig_nx   = EMPTY;
            w_dst_nx       = '0;
            w_cnt_nx       = '0;
            w_highlight_nx = '0;
            w_selected_nx  = 1'b0;
            w_turn_nx      = 1'b0;
            w_game_over_nx = 1'b0;
            w_qfig_nx      = '0;
            w_qpos_nx      = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.click_valid) begin
                        if (w_click_own) begin
                            w_sel_pos_nx   = bus.click_pos;
                            w_sel_fig_nx   = w_click_piece;
                            w_selected_nx  = 1'b1;
                            w_highlight_nx = '0;
                            w_cnt_nx       = 2'd1;
                            w_qfig_nx      = {1'b0, w_click_piece};
                            w_qpos_nx      = bus.click_pos;
                            w_state_nx     = ST_QUERY;
                        end else begin
                            w_illegal_nx = 1'b1;
                        end
                    end
                end

                // Query inputs are held from registers; the mask is sampled once the
                // generator has had MOVE_LAT cycles to settle.
                ST_QUERY: begin
                    if (r_cnt == 2'(MOVE_LAT)) begin
                        w_highlight_nx = w_mask;
                        w_qfig_nx      = '0;
                        if (w_mask == '0) begin
                            w_illegal_nx  = 1'b1;
                            w_selected_nx = 1'b0;
                            w_state_nx    = ST_IDLE;
                        end else begin
                            w_state_nx = ST_WAIT_DST;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 2'd1;
                    end
                end

                ST_WAIT_DST: begin
                    if (bus.click_valid) begin
                        if (bus.click_pos == r_sel_pos) begin
                            w_selected_nx  = 1'b0;
                            w_highlight_nx = '0;
                            w_state_nx     = ST_IDLE;
                        end else if (w_click_own) begin
                            w_sel_pos_nx   = bus.click_pos;
                            w_sel_fig_nx   = w_click_piece;
                            w_highlight_nx = '0;
                            w_cnt_nx       = 2'd1;
                            w_qfig_nx      = {1'b0, w_click_piece};
                            w_qpos_nx      = bus.click_pos;
                            w_state_nx     = ST_QUERY;
                        end else if (r_highlight[bus.click_pos]) begin
                            w_dst_nx   = bus.click_pos;
                            w_state_nx = ST_COMMIT;
                        end else begin
                            w_illegal_nx = 1'b1;
                        end
                    end
                end

                // Capturing a king ends the game with the capturing side still in turn.
                ST_COMMIT: begin
                    w_wr_en        = 1'b1;
                    w_selected_nx  = 1'b0;
                    w_highlight_nx = '0;
                    if (w_captured[2:0] == KING[2:0]) begin
                        w_game_over_nx = 1'b1;
                        w_state_nx     = ST_OVER;
                    end else begin
                        w_turn_nx      = ~r_turn;
                        w_move_done_nx = 1'b1;
                        w_state_nx     = ST_IDLE;
                    end
                end

                ST_OVER: ;

                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel_pos   <= '0;
            r_sel_fig   <= EMPTY;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_highlight <= '0;
            r_selected  <= 1'b0;
            r_turn      <= 1'b0;
            r_move_done <= 1'b0;
            r_illegal   <= 1'b0;
            r_game_over <= 1'b0;
            r_qfig      <= '0;
            r_qpos      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_sel_pos   <= w_sel_pos_nx;
            r_sel_fig   <= w_sel_fig_nx;
            r_dst       <= w_dst_nx;
            r_cnt       <= w_cnt_nx;
            r_highlight <= w_highlight_nx;
            r_selected  <= w_selected_nx;
            r_turn      <= w_turn_nx;
            r_move_done <= w_move_done_nx;
            r_illegal   <= w_illegal_nx;
            r_game_over <= w_game_over_nx;
            r_qfig      <= w_qfig_nx;
            r_qpos      <= w_qpos_nx;
        end
    end

    assign bus.query_figure = r_qfig;
    assign bus.query_pos    = r_qpos;
    assign bus.board        = w_board;
    assign bus.highlight    = r_highlight;
    assign bus.selected     = r_selected;
    assign bus.sel_pos      = r_sel_pos;
    assign bus.turn         = r_turn;
    assign bus.move_done    = r_move_done;
    assign bus.illegal      = r_illegal;
    assign bus.game_over    = r_game_over;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: a combinational move generator model (pawn pushes, or a
// forced mask), a vector table applied through an expectation queue, and a few
// hand-written multi-cycle sequences.
module tb_move_controller;
    import move_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_controller_if bus();

    move_controller #(.MOVE_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Generator model: forced mask when ovr_en, otherwise pawn pushes only.
    logic        ovr_en   = 1'b0;
    logic [63:0] ovr_mask = '0;

    function automatic logic [63:0] gen(logic [4:0] fig, logic [5:0] pos, board_t b);
        logic [255:0] f = b;
        logic [63:0]  m = '0;
        int s = int'(pos);
        int r = int'(pos[5:3]);
        if (fig[2:0] == 3'd1) begin
            if (!fig[3]) begin
                if (r < 7 && f[(s+8)*4 +: 3] == 3'd0) begin
                    m[s+8] = 1'b1;
                    if (r == 1 && f[(s+16)*4 +: 3] == 3'd0) m[s+16] = 1'b1;
                end
            end else begin
                if (r > 0 && f[(s-8)*4 +: 3] == 3'd0) begin
                    m[s-8] = 1'b1;
                    if (r == 6 && f[(s-16)*4 +: 3] == 3'd0) m[s-16] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    assign bus.possible_moves = ovr_en ? ovr_mask : gen(bus.query_figure, bus.query_pos, bus.board);

    // Start position written out independently: {row7, row6, rows5..2, row1, row0}, col0 = LSB nibble.
    localparam logic [255:0] EXP_INIT = {32'hABCEDCBA, 32'h99999999, 128'h0, 32'h11111111, 32'h23465432};

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [3:0] sq_of(input logic [5:0] sq);
        logic [255:0] f = bus.board;
        return f[int'(sq)*4 +: 4];
    endfunction

    function automatic logic [63:0] bm(input int n);
        return 64'd1 << n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ng;
        logic        cv;
        logic [5:0]  pos;
        logic        oe;
        logic [63:0] om;
        int          wt;
        logic        sel;
        logic [5:0]  spos;
        logic [63:0] hl;
        logic        trn;
        logic        ill;
        logic        done;
        logic        over;
        logic [5:0]  sq;
        logic [3:0]  sqv;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic add(input logic ng, input logic cv, input logic [5:0] pos, input logic oe,
                       input logic [63:0] om, input int wt, input logic sel, input logic [5:0] spos,
                       input logic [63:0] hl, input logic trn, input logic ill, input logic done,
                       input logic over, input logic [5:0] sq, input logic [3:0] sqv);
        vec_t v;
        v.ng = ng; v.cv = cv; v.pos = pos; v.oe = oe; v.om = om; v.wt = wt;
        v.sel = sel; v.spos = spos; v.hl = hl; v.trn = trn; v.ill = ill;
        v.done = done; v.over = over; v.sq = sq; v.sqv = sqv;
        vecs.push_back(v);
    endtask

    task automatic check_vec(input int i, input vec_t e);
        chk($sformatf("v%0d.selected", i), 256'(bus.selected), 256'(e.sel));
        if (e.sel) chk($sformatf("v%0d.sel_pos", i), 256'(bus.sel_pos), 256'(e.spos));
        chk($sformatf("v%0d.highlight", i), 256'(bus.highlight), 256'(e.hl));
        chk($sformatf("v%0d.turn", i), 256'(bus.turn), 256'(e.trn));
        chk($sformatf("v%0d.illegal", i), 256'(bus.illegal), 256'(e.ill));
        chk($sformatf("v%0d.move_done", i), 256'(bus.move_done), 256'(e.done));
        chk($sformatf("v%0d.game_over", i), 256'(bus.game_over), 256'(e.over));
        chk($sformatf("v%0d.board[%0d]", i, e.sq), 256'(sq_of(e.sq)), 256'(e.sqv));
    endtask

    initial begin
        bus.new_game    = 1'b0;
        bus.click_valid = 1'b0;
        bus.click_pos   = '0;

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.board", 256'(bus.board), EXP_INIT);
        chk("rst.turn", 256'(bus.turn), 256'd0);
        chk("rst.selected", 256'(bus.selected), 256'd0);
        chk("rst.highlight", 256'(bus.highlight), 256'd0);
        chk("rst.pulses", 256'({bus.move_done, bus.illegal, bus.game_over}), 256'd0);
        chk("rst.query_figure", 256'(bus.query_figure), 256'd0);

        // e2 pawn select + double push
        add(0,1,12, 0,0,          2, 1,12, bm(20)|bm(28), 0,0,0,0, 12,4'h1);
        add(0,1,28, 0,0,          2, 0,0,  0,             1,0,1,0, 28,4'h1);
        add(0,0,0,  0,0,          0, 0,0,  0,             1,0,1,0, 12,4'h0);
        // opponent square, blocked rook (own-square mask must be stripped)
        add(1,0,0,  0,0,          1, 0,0,  0,             0,0,0,0, 12,4'h1);
        add(0,1,52, 0,0,          1, 0,0,  0,             0,1,0,0, 52,4'h9);
        add(0,1,0,  1,bm(1)|bm(8),2, 0,0,  0,             0,1,0,0,  0,4'h2);
        // select, bad destination, reselect, deselect
        add(0,1,12, 0,0,          2, 1,12, bm(20)|bm(28), 0,0,0,0, 12,4'h1);
        add(0,1,36, 0,0,          1, 1,12, bm(20)|bm(28), 0,1,0,0, 36,4'h0);
        add(0,1,11, 0,0,          2, 1,11, bm(19)|bm(27), 0,0,0,0, 11,4'h1);
        add(0,1,11, 0,0,          1, 0,0,  0,             0,0,0,0, 11,4'h1);
        // queen takes king: game over, clicks ignored, new_game recovers
        add(0,1,3,  1,bm(60),     2, 1,3,  bm(60),        0,0,0,0, 60,4'hE);
        add(0,1,60, 1,bm(60),     2, 0,0,  0,             0,0,0,1, 60,4'h5);
        add(0,0,0,  1,bm(60),     0, 0,0,  0,             0,0,0,1,  3,4'h0);
        add(0,1,12, 0,0,          1, 0,0,  0,             0,0,0,1, 12,4'h1);
        add(1,0,0,  0,0,          1, 0,0,  0,             0,0,0,0, 60,4'hE);
        // new_game while waiting for destination; then white pawn promotion on row 7
        add(0,1,12, 0,0,          2, 1,12, bm(20)|bm(28), 0,0,0,0, 12,4'h1);
        add(1,0,0,  0,0,          1, 0,0,  0,             0,0,0,0, 12,4'h1);
        add(0,1,8,  1,bm(48),     2, 1,8,  bm(48),        0,0,0,0, 48,4'h9);
        add(0,1,48, 1,bm(48),     2, 0,0,  0,             1,0,1,0, 48,4'h1);
        add(0,1,49, 0,0,          2, 1,49, bm(41)|bm(33), 1,0,0,0, 49,4'h9);
        add(0,1,41, 0,0,          2, 0,0,  0,             0,0,1,0, 41,4'h9);
        add(0,1,48, 1,bm(57),     2, 1,48, bm(57),        0,0,0,0, 57,4'hB);
        add(0,1,57, 1,bm(57),     2, 0,0,  0,             1,0,1,0, 57,4'h5);

        foreach (vecs[i]) begin
            if (vecs[i].cv) begin
                ovr_en   = vecs[i].oe;
                ovr_mask = vecs[i].om;
            end
            bus.new_game    = vecs[i].ng;
            bus.click_valid = vecs[i].cv;
            bus.click_pos   = vecs[i].pos;
            exp_q.push_back(vecs[i]);
            if (vecs[i].wt > 0) tick();
            bus.new_game    = 1'b0;
            bus.click_valid = 1'b0;
            for (int k = 1; k < vecs[i].wt; k++) tick();
            check_vec(i, exp_q.pop_front());
        end

        // new_game restores the full start position
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        chk("ng.board", 256'(bus.board), EXP_INIT);
        chk("ng.turn", 256'(bus.turn), 256'd0);

        // Click during QUERY is dropped; query outputs held while querying
        ovr_en = 1'b0;
        bus.click_valid = 1'b1;
        bus.click_pos   = 6'd12;
        tick();
        chk("q.query_figure", 256'(bus.query_figure), 256'h01);
        chk("q.query_pos", 256'(bus.query_pos), 256'd12);
        bus.click_pos = 6'd52;
        tick();
        bus.click_valid = 1'b0;
        chk("q.drop_illegal", 256'(bus.illegal), 256'd0);
        chk("q.highlight", 256'(bus.highlight), 256'(bm(20) | bm(28)));
        chk("q.selected", 256'(bus.selected), 256'd1);
        chk("q.query_figure_idle", 256'(bus.query_figure), 256'd0);

        // Synchronous reset mid-selection
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.selected", 256'(bus.selected), 256'd0);
        chk("rst2.highlight", 256'(bus.highlight), 256'd0);
        chk("rst2.sel_pos", 256'(bus.sel_pos), 256'd0);
        chk("rst2.board", 256'(bus.board), EXP_INIT);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
